// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage (C) and a DMA/loader port (D).
// Optional DMEM_ARB_STATS_EN adds saturating conflict and stall counters.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_wr,
  input  logic        c_sb,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        m_wr,
  output logic        m_sb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic [1:0] {IDLE, CPU, DMA_LOCK} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic gnt_c, gnt_d, hold;
  always_comb begin
    // a full burst is held off for one cycle before the lock is released
    hold = state_q == DMA_LOCK && burst_q == BW'(BURST_MAX);
    gnt_d = d_req && !hold && (state_q == DMA_LOCK || starve_q == SW'(STARVE_MAX) || !c_req);
    gnt_c = c_req && !gnt_d;
    starve_d = (d_req && !gnt_d) ? (starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1) : '0;
    state_d = (gnt_d && d_lock) ? DMA_LOCK : gnt_c ? CPU : IDLE;
    burst_d = (gnt_d && d_lock) ? burst_q + 1'b1 : '0;
    d_rvalid_d = gnt_d && !d_wr;
    d_rdata_d = d_rvalid_d ? m_rdata : d_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      starve_q <= '0;
      burst_q <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      burst_q <= burst_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign m_wr     = gnt_c ? c_wr : gnt_d & d_wr;
  assign m_sb     = gnt_c & c_sb;
  assign m_addr   = gnt_c ? c_addr : gnt_d ? d_addr : '0;
  assign m_wdata  = gnt_c ? c_wdata : gnt_d ? d_wdata : '0;
  assign c_rdata  = m_rdata;
  assign c_stall  = c_req & ~gnt_c;
  assign d_ack    = gnt_d;
  assign d_rdata  = d_rdata_q;
  assign d_rvalid = d_rvalid_q;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d, stall_q, stall_d;
  always_comb begin
    conflict_d = (c_req && d_req && !(&conflict_q)) ? conflict_q + 1'b1 : conflict_q;
    stall_d = (c_stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      stall_q <= '0;
    end else begin
      conflict_q <= conflict_d;
      stall_q <= stall_d;
    end
  end
  assign conflict_cnt = conflict_q;
  assign stall_cnt    = stall_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a procedural reference model.
module tb_dmem_arbiter;
  localparam int SM = 4, BM = 8;
  logic clk = 0, rst_n = 0;
  logic c_req = 0, c_wr = 0, c_sb = 0, d_req = 0, d_wr = 0, d_lock = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic c_stall, d_ack, d_rvalid, m_wr, m_sb;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, stall_cnt;
`endif
  dmem_arbiter #(.STARVE_MAX(SM), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_wr(c_wr), .c_sb(c_sb), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_wr(d_wr), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_wr(m_wr), .m_sb(m_sb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a, input logic [31:0] d, input logic sb);
    logic [31:0] r;
    r = w;
    if (sb) r[8*a[1:0] +: 8] = d[7:0];
    else r = d;
    return r;
  endfunction
  logic [31:0] pmem [64];
  logic [31:0] rmem [64];
  assign m_rdata = pmem[m_addr[7:2]];
  always @(posedge clk) if (m_wr) pmem[m_addr[7:2]] <= merge(pmem[m_addr[7:2]], m_addr, m_wdata, m_sb);
  typedef struct {
    logic ack, stall, wr, sb, rv, chk_drd;
    logic [31:0] addr, wdata, crd, drd;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int nvec = 0, nbad = 0;
  int st = 0, starve = 0, burst = 0;
  logic rv = 0;
  logic [31:0] rd = 0;
  logic last_stall = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    if (a !== b) begin
      nbad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, a, b, $time);
    end
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    me = q.pop_front();
    chk("d_ack", {31'b0, d_ack}, {31'b0, me.ack});
    chk("c_stall", {31'b0, c_stall}, {31'b0, me.stall});
    chk("m_wr", {31'b0, m_wr}, {31'b0, me.wr});
    chk("m_sb", {31'b0, m_sb}, {31'b0, me.sb});
    chk("m_addr", m_addr, me.addr);
    chk("m_wdata", m_wdata, me.wdata);
    chk("c_rdata", c_rdata, me.crd);
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, me.rv});
    if (me.chk_drd) chk("d_rdata", d_rdata, me.drd);
  end
  task automatic rst_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n = 0;
      {c_req, c_wr, c_sb, d_req, d_wr, d_lock} = '0;
      {c_addr, c_wdata, d_addr, d_wdata} = '0;
      st = 0; starve = 0; burst = 0; rv = 0; rd = 0; last_stall = 0;
      e = '{ack: 0, stall: 0, wr: 0, sb: 0, rv: 0, chk_drd: 1, addr: 0, wdata: 0, crd: rmem[0], drd: 0};
      q.push_back(e);
      nvec++;
    end
  endtask
  task automatic step(input logic cr, input logic cw, input logic cs, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic dl, input logic [31:0] da, input logic [31:0] dd);
    exp_t e;
    logic gd, gc;
    @(posedge clk); #1;
    rst_n = 1;
    c_req = cr; c_wr = cw; c_sb = cs; c_addr = ca; c_wdata = cd;
    d_req = dr; d_wr = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    gd = dr && !(st == 2 && burst == BM) && (st == 2 || starve == SM || !cr);
    gc = cr && !gd;
    e.ack = gd;
    e.stall = cr && !gc;
    e.wr = gc ? cw : (gd && dw);
    e.sb = gc && cs;
    e.addr = gc ? ca : gd ? da : 32'h0;
    e.wdata = gc ? cd : gd ? dd : 32'h0;
    e.crd = rmem[e.addr[7:2]];
    e.rv = rv;
    e.drd = rd;
    e.chk_drd = rv;
    q.push_back(e);
    nvec++;
    if (gd && !dw) rd = e.crd;
    rv = gd && !dw;
    if (e.wr) rmem[e.addr[7:2]] = merge(rmem[e.addr[7:2]], e.addr, e.wdata, e.sb);
    starve = (dr && !gd) ? (starve < SM ? starve + 1 : SM) : 0;
    if (gd && dl) begin
      st = 2;
      burst++;
    end else begin
      st = gc ? 1 : 0;
      burst = 0;
    end
    last_stall = e.stall;
  endtask
  logic pcr, pcw, pcs;
  logic [31:0] pca, pcd;
  initial begin
    for (int i = 0; i < 64; i++) begin
      pmem[i] = 32'h1000_0000 + i * 32'h0101_0101;
      rmem[i] = pmem[i];
    end
    pmem[8] = 32'h1234_5678;
    rmem[8] = 32'h1234_5678;
    rst_cycles(2);
    step(1, 1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 32'h14, 0, 1, 1, 1, 32'h40 + 4 * i, 32'hA000_0000 + i);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h43, 32'h0000_00AB, 0, 0, 0, 0, 0);
    step(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 1, 32'h80 + 4 * i, 0);
    rst_cycles(1);
    step(1, 0, 0, 32'h20, 0, 1, 0, 1, 32'h84, 0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_cycles(1);
      if (!last_stall) begin
        pcr = $urandom_range(0, 2) != 0;
        pcw = $urandom_range(0, 1) == 1;
        pcs = $urandom_range(0, 3) == 0;
        pca = 32'($urandom_range(0, 255));
        pcd = $urandom;
      end
      step(pcr, pcw, pcs, pca, pcd,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           32'($urandom_range(0, 63)) << 2, $urandom);
    end
    @(negedge clk); #1;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
